// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the shift_registers family.
package shift_reg_pkg;

  // Two-state serializer control: waiting for a word, or shifting one out.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    int w;
    for (w = 1; (1 << w) < n; w++) begin
    end
    return w;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Loadable shift register with a serial-out tap at the output end.
// Load wins over shift; vacated positions are filled with zero.
module piso_shreg
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] shreg_reg;

  // Hold, load a new word, or move one place toward the output end.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_reg <= '0;
    end else if (load) begin
      shreg_reg <= din;
    end else if (shift_en) begin
      if (MSB_FIRST) begin
        shreg_reg <= {shreg_reg[WIDTH-2:0], 1'b0};
      end else begin
        shreg_reg <= {1'b0, shreg_reg[WIDTH-1:1]};
      end
    end
  end

  assign sout = MSB_FIRST ? shreg_reg[WIDTH-1] : shreg_reg[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter. A word taken over valid/ready is
// emitted one bit per clock; the next word can be taken on the last bit
// so back-to-back words stream with no gap.
module piso_serializer
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             o_sd,
  output logic             o_sv,
  output logic             o_last,
  output logic             o_busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic          at_last;
  logic          shifting;
  logic          accept;
  logic          tap;

  assign shifting = (state_reg == ST_SHIFT);
  assign at_last  = (cnt_reg == LAST_CNT);
  // Ready depends only on registered state so there is no valid->ready loop.
  assign in_ready = (state_reg == ST_IDLE) | (shifting & at_last);
  assign accept   = in_valid & in_ready;

  // Control FSM and bit counter; the counter reloads instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg <= ST_SHIFT;
            cnt_reg   <= '0;
          end
        end
        ST_SHIFT: begin
          if (!at_last) begin
            cnt_reg <= cnt_reg + CW'(1);
          end else if (accept) begin
            cnt_reg <= '0;
          end else begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift_en (shifting & ~at_last),
    .din      (in_data),
    .sout     (tap)
  );

  // Outputs come from registered state only; data is forced low when idle.
  assign o_sv   = shifting;
  assign o_busy = shifting;
  assign o_sd   = shifting & tap;
  assign o_last = shifting & at_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first, LSB-first and 8-bit builds.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // MSB-first, WIDTH=4
  logic [3:0] a_data;
  logic       a_valid, a_ready, a_sd, a_sv, a_last, a_busy;
  // LSB-first, WIDTH=4
  logic [3:0] b_data;
  logic       b_valid, b_ready, b_sd, b_sv, b_last, b_busy;
  // MSB-first, WIDTH=8
  logic [7:0] c_data;
  logic       c_valid, c_ready, c_sd, c_sv, c_last, c_busy;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .o_sd(a_sd), .o_sv(a_sv), .o_last(a_last), .o_busy(a_busy)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .o_sd(b_sd), .o_sv(b_sv), .o_last(b_last), .o_busy(b_busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_w8 (
    .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid),
    .in_ready(c_ready), .o_sd(c_sd), .o_sv(c_sv), .o_last(c_last), .o_busy(c_busy)
  );

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 0; b_valid = 0; c_valid = 0;
    a_data = '0; b_data = '0; c_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({a_sd, a_sv, a_last, a_busy, a_ready} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_msb got sd/sv/last/busy/ready=%b want 00001",
               {a_sd, a_sv, a_last, a_busy, a_ready});
    end
    total++;
    if ({b_sd, b_sv, b_last, b_busy, b_ready} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_lsb got %b want 00001", {b_sd, b_sv, b_last, b_busy, b_ready});
    end
    total++;
    if ({c_sd, c_sv, c_last, c_busy, c_ready} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_w8 got %b want 00001", {c_sd, c_sv, c_last, c_busy, c_ready});
    end
    $display("reset: outputs idle, in_ready=%b/%b/%b", a_ready, b_ready, c_ready);
  endtask

  // Test 1: single word 1011 MSB first; expected bit for cycle k is seq[4-k].
  task automatic test_msb_single();
    logic [3:0] seq = 4'b1011;
    a_data = 4'b1011; a_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      logic exp_sd, exp_sv, exp_last, exp_rdy;
      @(negedge clk);
      a_valid = 1'b0;
      a_data  = 4'b0101;
      exp_sv   = (k <= 4);
      exp_sd   = (k <= 4) ? seq[4-k] : 1'b0;
      exp_last = (k == 4);
      exp_rdy  = (k >= 4);
      total++;
      if ({a_sd, a_sv, a_last, a_busy, a_ready} !== {exp_sd, exp_sv, exp_last, exp_sv, exp_rdy}) begin
        bad++;
        $display("FAIL msb_single cyc%0d got sd/sv/last/busy/ready=%b want %b", k,
                 {a_sd, a_sv, a_last, a_busy, a_ready}, {exp_sd, exp_sv, exp_last, exp_sv, exp_rdy});
      end
    end
    $display("msb_single: word 1011 shifted out");
  endtask

  // Test 2: 1011 then 0110 with valid held; contiguous 8-bit stream.
  task automatic test_back_to_back();
    logic [7:0] seq = 8'b1011_0110;
    a_data = 4'b1011; a_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      logic exp_sd, exp_sv, exp_last;
      @(negedge clk);
      exp_sv   = (k <= 8);
      exp_sd   = (k <= 8) ? seq[8-k] : 1'b0;
      exp_last = (k == 4) || (k == 8);
      total++;
      if ({a_sd, a_sv, a_last, a_busy} !== {exp_sd, exp_sv, exp_last, exp_sv}) begin
        bad++;
        $display("FAIL back_to_back cyc%0d got sd/sv/last/busy=%b want %b", k,
                 {a_sd, a_sv, a_last, a_busy}, {exp_sd, exp_sv, exp_last, exp_sv});
      end
      if (k == 1) a_data = 4'b0110;
      if (k == 5) a_valid = 1'b0;
    end
    $display("back_to_back: 1011,0110 streamed");
  endtask

  // Test 3: LSB first, 1011 emits 1,1,0,1.
  task automatic test_lsb_first();
    logic [3:0] seq = 4'b1101;
    b_data = 4'b1011; b_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      logic exp_sd, exp_sv, exp_last;
      @(negedge clk);
      b_valid = 1'b0;
      exp_sv   = (k <= 4);
      exp_sd   = (k <= 4) ? seq[4-k] : 1'b0;
      exp_last = (k == 4);
      total++;
      if ({b_sd, b_sv, b_last, b_busy} !== {exp_sd, exp_sv, exp_last, exp_sv}) begin
        bad++;
        $display("FAIL lsb_first cyc%0d got sd/sv/last/busy=%b want %b", k,
                 {b_sd, b_sv, b_last, b_busy}, {exp_sd, exp_sv, exp_last, exp_sv});
      end
    end
    $display("lsb_first: word 1011 shifted out");
  endtask

  // Test 4: reset during cycle 2 drops the rest of the word.
  task automatic test_mid_reset();
    a_data = 4'b1111; a_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      logic exp_sd, exp_sv, exp_rdy;
      @(negedge clk);
      a_valid = 1'b0;
      exp_sv  = (k <= 2);
      exp_sd  = (k <= 2);
      exp_rdy = (k >= 3);
      total++;
      if ({a_sd, a_sv, a_last, a_busy, a_ready} !== {exp_sd, exp_sv, 1'b0, exp_sv, exp_rdy}) begin
        bad++;
        $display("FAIL mid_reset cyc%0d got sd/sv/last/busy/ready=%b want %b", k,
                 {a_sd, a_sv, a_last, a_busy, a_ready}, {exp_sd, exp_sv, 1'b0, exp_sv, exp_rdy});
      end
      rst = (k == 2);
    end
    $display("mid_reset: word aborted");
  endtask

  // Test 5: valid with 0000 during SHIFT is ignored.
  task automatic test_ignore_busy();
    a_data = 4'b1111; a_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      logic exp_sv, exp_rdy;
      @(negedge clk);
      a_data  = 4'b0000;
      a_valid = (k <= 2);
      exp_sv  = (k <= 4);
      exp_rdy = (k >= 4);
      total++;
      if ({a_sd, a_sv, a_last, a_ready} !== {exp_sv, exp_sv, (k == 4), exp_rdy}) begin
        bad++;
        $display("FAIL ignore_busy cyc%0d got sd/sv/last/ready=%b want %b", k,
                 {a_sd, a_sv, a_last, a_ready}, {exp_sv, exp_sv, (k == 4), exp_rdy});
      end
    end
    $display("ignore_busy: word 1111 unaffected");
  endtask

  // Test 6: 8-bit word A5 MSB first.
  task automatic test_width8();
    logic [7:0] seq = 8'b1010_0101;
    c_data = 8'hA5; c_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      logic exp_sd, exp_sv, exp_last;
      @(negedge clk);
      c_valid = 1'b0;
      exp_sv   = (k <= 8);
      exp_sd   = (k <= 8) ? seq[8-k] : 1'b0;
      exp_last = (k == 8);
      total++;
      if ({c_sd, c_sv, c_last, c_busy} !== {exp_sd, exp_sv, exp_last, exp_sv}) begin
        bad++;
        $display("FAIL width8 cyc%0d got sd/sv/last/busy=%b want %b", k,
                 {c_sd, c_sv, c_last, c_busy}, {exp_sd, exp_sv, exp_last, exp_sv});
      end
    end
    $display("width8: word A5 shifted out");
  endtask

  initial begin
    test_reset();
    test_msb_single();
    test_back_to_back();
    test_lsb_first();
    test_mid_reset();
    test_ignore_busy();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, with a bit-valid strobe and a last-bit flag.
- Feeds serial shift-register chains and serial receivers in the shift_registers family.
- Supports back-to-back words with no idle gap between them.

Parameters:
- WIDTH, 4, word length in bits; legal range is WIDTH >= 2.
- MSB_FIRST, 1, bit order: 1 = bit WIDTH-1 goes out first, 0 = bit 0 goes out first.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_data  input  WIDTH  parallel word; sampled only on an accept.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can take a word this cycle.
- o_sd  output  1  serial data bit; driven 0 whenever o_sv = 0.
- o_sv  output  1  o_sd carries a valid bit this cycle.
- o_last  output  1  current bit is the final bit of the word; asserts only together with o_sv.
- o_busy  output  1  a word is being shifted out; equal to o_sv.

Behaviour:
- Reset (rst = 1 at a clock edge): state = IDLE, shift register = 0, bit counter = 0, o_sd = 0, o_sv = 0, o_last = 0, o_busy = 0.
  - in_ready is combinational and reads 1 in IDLE, so it is 1 in the cycle after reset.
  - rst has priority over everything. A reset mid-word drops the remaining bits; no partial word resumes.
- States: IDLE and SHIFT.
- Accept: in_valid & in_ready at a rising edge.
- in_ready = (state == IDLE) | (state == SHIFT & counter == WIDTH-1). It is combinational from state and counter only, never from in_valid.
- IDLE, on accept:
  - load the shift register with in_data;
  - set counter = 0;
  - go to SHIFT.
  - Without an accept, stay in IDLE.
- SHIFT, every cycle:
  - o_sv = 1;
  - o_sd = shreg[WIDTH-1] if MSB_FIRST, else shreg[0];
  - o_last = (counter == WIDTH-1).
  - On each edge where counter < WIDTH-1: shift toward the output end (left if MSB_FIRST, right otherwise), fill with 0, counter increments.
- SHIFT, at the last bit (counter == WIDTH-1):
  - with an accept: reload the shift register, counter = 0, stay in SHIFT. The next word's first bit appears the very next cycle, so the stream has no gap.
  - without an accept: go to IDLE; o_sv drops the next cycle.
- Latency: the first bit is on o_sd in the cycle immediately after the accept edge. A word occupies exactly WIDTH consecutive o_sv cycles.
- Throughput: one word per WIDTH cycles under continuous in_valid.
- in_valid while in_ready = 0 is ignored: no capture and no state change. The upstream side must hold its word until it is accepted.
- in_data changing while not accepted has no effect.
- Counter width is clog2(WIDTH). The counter never wraps past WIDTH-1 because it reloads to 0.
- Outputs o_sd, o_sv, o_last and o_busy are derived from registered state and the shift register only; no combinational path from the inputs.

Decomposition:
- Shared package shift_reg_pkg holds:
  - the state enum (ST_IDLE, ST_SHIFT);
  - a count-width helper function (clog2 with a minimum of 1).
- One natural sub-module, piso_shreg: a WIDTH-bit loadable shift register with load, shift enable, MSB_FIRST direction and a serial-out tap, synchronous active-high rst.
- The top level holds the FSM, the counter and the handshake.

Test Plan (WIDTH = 4 unless noted):
1. MSB_FIRST = 1, accept 4'b1011 at cycle 0 -> o_sd = 1,0,1,1 on cycles 1–4; o_sv = 1 on cycles 1–4; o_last only on cycle 4; in_ready = 1 on cycle 4; o_sv = 0 on cycle 5.
2. Back-to-back, in_valid held high with 4'b1011 then 4'b0110 -> 8 contiguous o_sv cycles with o_sd = 1,0,1,1,0,1,1,0; o_last on cycles 4 and 8; second word accepted at the cycle-4 edge.
3. MSB_FIRST = 0, accept 4'b1011 -> o_sd = 1,1,0,1 (LSB first).
4. Accept 4'b1111, then assert rst on cycle 2 -> at the following edge o_sv = o_sd = o_last = 0, state IDLE, in_ready = 1; no further bits are emitted.
5. During SHIFT (cycles 1–3), pulse in_valid with 4'b0000 -> ignored; output stream stays 1,1,1,1 for a word of 4'b1111; in_ready stays 0 on cycles 1–3.
6. WIDTH = 8, MSB_FIRST = 1, accept 8'hA5 -> o_sd = 1,0,1,0,0,1,0,1 on cycles 1–8; o_last on cycle 8; then IDLE.
